// File: rtl/pipe_stage_hs.sv
// Elastic pipeline stage with a valid/ready handshake on both sides.
//
// A head (main) register and a skid register let the stage absorb one
// extra payload while downstream stalls, so both in_ready_o and out_valid_o
// come straight from state and no combinational ready path crosses the
// stage. A synchronous flush empties the stage for redirects, and a
// saturating counter records cycles in which downstream held off a valid
// payload.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   flush_i      discard all buffered entries this cycle
//   in_valid_i   upstream has a payload
//   in_ready_o   stage can accept a payload (registered)
//   in_data_i    upstream payload
//   out_valid_o  stage holds a payload for downstream (registered)
//   out_ready_i  downstream accepts the payload
//   out_data_o   head payload
//   occupancy_o  number of buffered entries (0..2)
//   stall_cnt_o  saturating count of cycles with out_valid_o=1, out_ready_i=0
module pipe_stage_hs #(
   parameter int unsigned      WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_DATA = '0,
   parameter int unsigned      CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o,
   output logic [1:0]       occupancy_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   // Encoding equals the occupancy count.
   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic in_fire;
   logic out_fire;

   assign in_ready_o  = (state_q != StFull);
   assign out_valid_o = (state_q != StEmpty);
   assign out_data_o  = main_q;
   assign occupancy_o = state_q;
   assign stall_cnt_o = stall_q;

   assign in_fire  = in_valid_i & in_ready_o;
   assign out_fire = out_valid_o & out_ready_i;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      if (flush_i) begin
         // Data registers are left alone; they are don't-care once empty.
         state_d = StEmpty;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (in_fire) begin
                  state_d = StOne;
                  main_d  = in_data_i;
               end
            end
            StOne: begin
               if (in_fire && out_fire) begin
                  main_d = in_data_i;
               end else if (in_fire) begin
                  state_d = StFull;
                  skid_d  = in_data_i;
               end else if (out_fire) begin
                  state_d = StEmpty;
               end
            end
            StFull: begin
               // in_ready_o is low here, so only the drain case exists.
               if (out_fire) begin
                  state_d = StOne;
                  main_d  = skid_q;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   // Counts the flush cycle too: the stall was visible to downstream.
   always_comb begin
      stall_d = stall_q;
      if (out_valid_o && !out_ready_i && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StEmpty;
         main_q  <= RESET_DATA;
         skid_q  <= RESET_DATA;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         stall_q <= stall_d;
      end
   end

endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
- Elastic pipeline stage register with a valid/ready handshake on both sides and a 2-entry skid buffer.
- Both `in_ready_o` and `out_valid_o` are registered, so neither side sees a combinational ready path.
- Replaces the free-running stage flop wherever a stage must absorb a downstream stall without losing data, e.g. fetch→decode and execute→memory.
- Adds a synchronous flush for branch/exception redirects and a stall-cycle counter for performance monitoring.

Parameters:
- WIDTH, 32, payload width in bits.
- RESET_DATA, 0, value of `out_data_o` after reset.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush_i  input  1  discard all buffered entries this cycle.
- in_valid_i  input  1  upstream has a payload.
- in_ready_o  output  1  stage can accept a payload.
- in_data_i  input  WIDTH  upstream payload.
- out_valid_o  output  1  stage holds a payload for downstream.
- out_ready_i  input  1  downstream accepts the payload.
- out_data_o  output  WIDTH  head payload.
- occupancy_o  output  2  number of buffered entries (0..2).
- stall_cnt_o  output  CNT_W  cycles in which `out_valid_o`=1 and `out_ready_i`=0.

Behaviour:
- Clocking: one clock `clk`. Reset `rst` is synchronous and active-high.
- Definitions: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- Storage: main register (head) and skid register. State EMPTY/ONE/FULL is encoded as 2-bit occupancy.
- Outputs derived from state only:
  - `in_ready_o` = (state != FULL).
  - `out_valid_o` = (state != EMPTY).
  - `out_data_o` = main register.
  - `occupancy_o` = 0/1/2 for EMPTY/ONE/FULL.
- Reset: state=EMPTY, main=skid=RESET_DATA, `stall_cnt_o`=0. Hence after reset `in_ready_o`=1, `out_valid_o`=0, `out_data_o`=RESET_DATA, `occupancy_o`=0.
- Transitions (when no flush and no reset):
  - EMPTY, in_fire → ONE; main<=in_data_i.
  - ONE, in_fire & out_fire → ONE; main<=in_data_i.
  - ONE, in_fire & !out_fire → FULL; skid<=in_data_i.
  - ONE, !in_fire & out_fire → EMPTY.
  - FULL, out_fire → ONE; main<=skid. No in_fire is possible in FULL.
  - Any state with no fire holds; the payload is stable while `out_valid_o`=1 and `out_ready_i`=0.
- Latency: 1 cycle from in_fire to `out_valid_o` when the stage was EMPTY, or ONE with out_fire.
- Throughput: 1 payload/cycle sustained while `out_ready_i`=1.
- Ordering: strict FIFO. No payload is duplicated or dropped except by flush.
- Flush: next state=EMPTY regardless of in/out fire.
  - Data registers keep their contents (don't-care while `out_valid_o`=0).
  - An out_fire in the flush cycle counts as delivered, since downstream sampled it.
  - An in_fire in the flush cycle is discarded.
- Priority: rst > flush_i > handshake updates.
- Stall counter:
  - +1 each cycle `out_valid_o`=1 and `out_ready_i`=0, including the flush cycle.
  - Saturates at 2^CNT_W-1.
  - Cleared only by rst.
- Reset mid-operation: all contents are lost; outputs return to reset values on the next edge.
- Ignored inputs: `in_data_i` is ignored when in_fire=0. `out_ready_i` is ignored when EMPTY.

Test Plan:
- Stream test: rst 2 cycles, then `out_ready_i`=1 and push 0x11,0x22,0x33 on consecutive cycles → `out_data_o` shows 0x11,0x22,0x33 on cycles 1,2,3 after each push. `occupancy_o` stays 1, `stall_cnt_o`=0.
- Backpressure test: `out_ready_i`=0, push 0xA, then 0xB → `occupancy_o`=2, `in_ready_o`=0, `out_data_o`=0xA. A third push 0xC is held upstream. Raise `out_ready_i` → outputs 0xA, 0xB, 0xC in order, nothing lost.
- Flush test: with FULL (0xA,0xB) assert `flush_i` together with `in_valid_i` carrying 0xD → next cycle `occupancy_o`=0, `out_valid_o`=0. 0xD never appears at the output.
- Simultaneous in/out in ONE: hold 0x5, push 0x6 with `out_ready_i`=1 → 0x5 delivered, `out_data_o`=0x6 next cycle, `occupancy_o` stays 1.
- Stall counter: CNT_W=4, hold `out_ready_i`=0 with one entry for 20 cycles → `stall_cnt_o` saturates at 15. Then rst → 0.
- Reset mid-operation: FULL state, assert rst for 1 cycle → `out_valid_o`=0, `in_ready_o`=1, `out_data_o`=RESET_DATA, `occupancy_o`=0.
